pwm_bus_arbiter: RTL and testbench
==================================

PWM_BUS_ARBITER -- requirements
Module: pwm_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, number of register-bus requesters (index 0 = SPI bridge).
REQ-002 The block SHALL have parameter N_INST, default 4, number of PWM instances on the bus (power of two, 1..4).
REQ-003 The block SHALL have parameter DATA_W, default 8, register data width.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 req_i  input  N_REQ  per-requester transaction request, held until gnt_o.
REQ-007 addr_i  input  N_REQ*8  per-requester address; [7:6] instance select, [5:0] register offset.
REQ-008 wdata_i  input  N_REQ*DATA_W  per-requester write data.
REQ-009 we_i  input  N_REQ  per-requester write enable (1 = write, 0 = read).
REQ-010 gnt_o  output  N_REQ  one-cycle grant pulse; request accepted.
REQ-011 rvalid_o  output  N_REQ  one-cycle completion pulse, for reads and writes.
REQ-012 rdata_o  output  DATA_W  read data, valid with rvalid_o.
REQ-013 rerr_o  output  1  completion error flag, valid with rvalid_o.
REQ-014 b_addr_o  output  8  shared register address to all instances.
REQ-015 b_data_o  output  DATA_W  shared write data to all instances.
REQ-016 b_write_o  output  N_INST  per-instance one-cycle write strobe.
REQ-017 b_data_i  input  N_INST*DATA_W  per-instance read data, combinational from b_addr_o.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, RESP; IDLE->ISSUE when any req_i bit is high, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 In IDLE at cycle T, the winner SHALL be chosen round-robin: the lowest index above the last-served index, wrapping; after reset last-served = N_REQ-1, so requester 0 wins first.
REQ-020 At T the winner's index, addr, wdata and we SHALL be latched; later changes on that requester's inputs have no effect.
REQ-021 In ISSUE (T+1): gnt_o[winner]=1, b_addr_o/b_data_o = latched values, b_write_o[addr[7:6]]=1 iff write and instance index < N_INST.
REQ-022 In RESP (T+2): rvalid_o[winner]=1; rdata_o = b_data_i of the selected instance as sampled at end of ISSUE for a valid read, else 0.
REQ-023 Instance index >= N_INST SHALL produce no write strobe, rdata_o = 0, rerr_o = 1; otherwise rerr_o = 0.
REQ-024 Throughput SHALL be one transaction per 3 cycles; no arbitration in ISSUE or RESP.
REQ-025 A requester still asserting req_i in the cycle after its gnt_o SHALL be treated as a new request.
REQ-026 Simultaneous requests SHALL be served strictly round-robin; no requester waits more than N_REQ transactions.
REQ-027 b_addr_o and b_data_o SHALL hold last issued values outside ISSUE; b_write_o, gnt_o and rvalid_o SHALL be 0 outside their state.
REQ-028 rdata_o and rerr_o SHALL hold until the next RESP.

Reset
REQ-029 On rst_i: state = IDLE, last-served = N_REQ-1, all outputs 0.
REQ-030 rst_i in ISSUE or RESP SHALL abort the transaction: no rvalid_o, and no write strobe in the following cycle.
REQ-031 rst_i SHALL take priority over all requests.

Structure
REQ-032 A shared package SHALL hold the state enum, the instance-field position constants (7:6) and the register-offset width.
REQ-033 The round-robin selector SHALL be a sub-module, rr_arbiter (request vector and last-served index in; one-hot winner and index out).

Verification
REQ-034 Single write: req0, addr 0x45, wdata 0xA5, we=1 at T -> gnt_o[0] at T+1, b_write_o=0b0010, b_addr_o=0x45, rvalid_o[0] at T+2, rerr_o=0.
REQ-035 Single read: instance 2 returns 0x3C for addr 0x81 -> rdata_o=0x3C with rvalid_o[1] at T+2, no write strobe.
REQ-036 Contention: req0 and req1 held continuously -> grants alternate 0,1,0,1 every 3 cycles, starting with 0 after reset.
REQ-037 Out-of-range: N_INST=2, write to addr 0xC0 -> b_write_o=0, rerr_o=1, rdata_o=0x00.
REQ-038 Reset mid-transaction: rst_i high in ISSUE -> no rvalid_o, IDLE next cycle, next grant goes to requester 0.

Source files
------------

// File: rtl/pwm_bus_arbiter_pkg.sv
// pwm_bus_arbiter_pkg: shared FSM encoding and register-address field layout for the PWM bus arbiter.
package pwm_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
    localparam int OFF_W   = 6;
    localparam int INST_LO = OFF_W;
    localparam int INST_HI = 7;
endpackage

// File: rtl/pwm_bus_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick of the lowest requesting index above the last-served one, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    int j;
    // Scan from farthest to nearest so the nearest requester above last_i overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last_i) + k) % N;
            if (req_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = IW'(j);
            end
        end
    end
endmodule

// File: rtl/pwm_bus_arbiter.sv
// pwm_bus_arbiter: shares one register bus among N_REQ requesters, one transaction every three cycles.
module pwm_bus_arbiter
    import pwm_bus_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int N_INST = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*8-1:0]       addr_i,
    input  logic [N_REQ*DATA_W-1:0]  wdata_i,
    input  logic [N_REQ-1:0]         we_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rerr_o,
    output logic [7:0]               b_addr_o,
    output logic [DATA_W-1:0]        b_data_o,
    output logic [N_INST-1:0]        b_write_o,
    input  logic [N_INST*DATA_W-1:0] b_data_i
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    state_e              state_q, state_d;
    logic [IW-1:0]       last_q, win_idx;
    logic [N_REQ-1:0]    win_oh, win_oh_q;
    logic [7:0]          addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q, sel_data;
    logic                we_q, rerr_q, inst_ok;
    logic [1:0]          inst;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (win_oh),
        .idx_o  (win_idx)
    );

    assign inst     = addr_q[INST_HI:INST_LO];
    assign inst_ok  = int'(inst) < N_INST;
    assign b_addr_o = addr_q;
    assign b_data_o = wdata_q;
    assign rdata_o  = rdata_q;
    assign rerr_o   = rerr_q;

    // Strobes are masked by rst_i so an aborted transaction never reaches the bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_INST; i++)
            sel_data = (int'(inst) == i) ? b_data_i[i*DATA_W +: DATA_W] : sel_data;
        state_d  = (state_q == IDLE) ? (|req_i ? ISSUE : IDLE) : (state_q == ISSUE) ? RESP : IDLE;
        gnt_o    = (state_q == ISSUE && !rst_i) ? win_oh_q : '0;
        rvalid_o = (state_q == RESP && !rst_i) ? win_oh_q : '0;
        b_write_o = '0;
        for (int i = 0; i < N_INST; i++)
            b_write_o[i] = state_q == ISSUE && !rst_i && we_q && int'(inst) == i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= IW'(N_REQ - 1);
            win_oh_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_i) begin
                last_q   <= win_idx;
                win_oh_q <= win_oh;
                addr_q   <= addr_i[int'(win_idx)*8 +: 8];
                wdata_q  <= wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                we_q     <= we_i[win_idx];
            end
            if (state_q == ISSUE) begin
                rdata_q <= (inst_ok && !we_q) ? sel_data : '0;
                rerr_q  <= !inst_ok;
            end
        end
    end
endmodule

// File: tb/tb_pwm_bus_arbiter.sv
// tb_pwm_bus_arbiter: directed and random checks of two arbiter builds (4 and 2 instances) against a transaction model.
module tb_pwm_bus_arbiter;
    localparam int NR = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]    req, we;
    logic [NR*8-1:0]  addr;
    logic [NR*DW-1:0] wdata;

    logic [NR-1:0] gnt_a, rv_a, gnt_b, rv_b;
    logic [DW-1:0] rd_a, bd_a, rd_b, bd_b;
    logic          re_a, re_b;
    logic [7:0]    ba_a, ba_b;
    logic [3:0]    bw_a;
    logic [1:0]    bw_b;
    logic [4*DW-1:0] bi_a;
    logic [2*DW-1:0] bi_b;

    int n_chk = 0;
    int n_fail = 0;

    int ph, last, win;
    logic [7:0]    m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [DW-1:0] m_rd[2];
    logic          m_re[2];

    always #5 clk = ~clk;

    pwm_bus_arbiter #(.N_REQ(NR), .N_INST(4), .DATA_W(DW)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata), .we_i(we),
        .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rd_a), .rerr_o(re_a),
        .b_addr_o(ba_a), .b_data_o(bd_a), .b_write_o(bw_a), .b_data_i(bi_a)
    );

    pwm_bus_arbiter #(.N_REQ(NR), .N_INST(2), .DATA_W(DW)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .wdata_i(wdata), .we_i(we),
        .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rd_b), .rerr_o(re_b),
        .b_addr_o(ba_b), .b_data_o(bd_b), .b_write_o(bw_b), .b_data_i(bi_b)
    );

    function automatic logic [7:0] inst_data(int k, logic [7:0] a);
        return (k == 2 && a == 8'h81) ? 8'h3C : 8'((a * 8'd5) ^ 8'(k * 8'h33) ^ 8'h5A);
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) bi_a[k*DW +: DW] = inst_data(k, ba_a);
        for (int k = 0; k < 2; k++) bi_b[k*DW +: DW] = inst_data(k, ba_b);
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the transaction model, compare both builds.
    task automatic step();
        logic [NR-1:0]    r = req;
        logic [NR*8-1:0]  a = addr;
        logic [NR*DW-1:0] d = wdata;
        logic [NR-1:0]    w = we;
        logic             rs = rst;
        int inst, eg, er;
        @(posedge clk);
        #1;
        if (rs) begin
            ph = 0; last = NR - 1; m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_rd[0] = '0; m_rd[1] = '0; m_re[0] = 1'b0; m_re[1] = 1'b0;
        end else if (ph == 0) begin
            if (r != 0) begin
                for (int i = 1; i <= NR; i++)
                    if (r[(last + i) % NR]) begin
                        win = (last + i) % NR;
                        break;
                    end
                last = win;
                m_addr = a[win*8 +: 8];
                m_wdata = d[win*DW +: DW];
                m_we = w[win];
                ph = 1;
            end
        end else if (ph == 1) begin
            ph = 2;
            for (int v = 0; v < 2; v++) begin
                int ni = v ? 2 : 4;
                int k = int'(m_addr[7:6]);
                m_re[v] = k >= ni;
                m_rd[v] = (k < ni && !m_we) ? inst_data(k, m_addr) : '0;
            end
        end else ph = 0;
        inst = int'(m_addr[7:6]);
        eg = (ph == 1) ? (1 << win) : 0;
        er = (ph == 2) ? (1 << win) : 0;
        chk("gnt_a", 32'(gnt_a), eg);
        chk("gnt_b", 32'(gnt_b), eg);
        chk("rvalid_a", 32'(rv_a), er);
        chk("rvalid_b", 32'(rv_b), er);
        chk("baddr_a", 32'(ba_a), 32'(m_addr));
        chk("baddr_b", 32'(ba_b), 32'(m_addr));
        chk("bdata_a", 32'(bd_a), 32'(m_wdata));
        chk("bdata_b", 32'(bd_b), 32'(m_wdata));
        chk("bwrite_a", 32'(bw_a), (ph == 1 && m_we) ? (1 << inst) : 0);
        chk("bwrite_b", 32'(bw_b), (ph == 1 && m_we && inst < 2) ? (1 << inst) : 0);
        chk("rdata_a", 32'(rd_a), 32'(m_rd[0]));
        chk("rdata_b", 32'(rd_b), 32'(m_rd[1]));
        chk("rerr_a", 32'(re_a), 32'(m_re[0]));
        chk("rerr_b", 32'(re_b), 32'(m_re[1]));
    endtask

    initial begin
        rst = 1'b1; req = '0; addr = '0; wdata = '0; we = '0;
        step();
        step();
        rst = 1'b0;
        // single write to instance 1
        req = 2'b01; addr[7:0] = 8'h45; wdata[7:0] = 8'hA5; we[0] = 1'b1;
        step();
        chk("wr_gnt", 32'(gnt_a), 1);
        chk("wr_bwrite", 32'(bw_a), 32'b0010);
        chk("wr_baddr", 32'(ba_a), 32'h45);
        req = '0; addr[7:0] = 8'hFF;
        step();
        chk("wr_rvalid", 32'(rv_a), 1);
        chk("wr_rerr", 32'(re_a), 0);
        step();
        // single read from instance 2
        req = 2'b10; addr[15:8] = 8'h81; we[1] = 1'b0;
        step();
        chk("rd_gnt", 32'(gnt_a), 2);
        chk("rd_bwrite", 32'(bw_a), 0);
        req = '0;
        step();
        chk("rd_rvalid", 32'(rv_a), 2);
        chk("rd_rdata", 32'(rd_a), 32'h3C);
        step();
        // out-of-range write on the two-instance build
        req = 2'b01; addr[7:0] = 8'hC0; wdata[7:0] = 8'h11; we[0] = 1'b1;
        step();
        chk("oor_bwrite", 32'(bw_b), 0);
        req = '0;
        step();
        chk("oor_rerr", 32'(re_b), 1);
        chk("oor_rdata", 32'(rd_b), 0);
        step();
        // contention after reset
        rst = 1'b1;
        step();
        rst = 1'b0; req = 2'b11; we = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k % 3 == 0) chk("rr_gnt", 32'(gnt_a), ((k / 3) % 2) ? 2 : 1);
        end
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_gnt", 32'(gnt_a), 2);
        rst = 1'b1;
        step();
        chk("rst_rvalid", 32'(rv_a), 0);
        chk("rst_bwrite", 32'(bw_a), 0);
        rst = 1'b0;
        step();
        chk("rst_next_gnt", 32'(gnt_a), 1);
        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rst = $urandom_range(0, 59) == 0;
            for (int i = 0; i < NR; i++)
                if (!req[i] || (ph == 1 && win == i)) begin
                    req[i] = $urandom_range(0, 2) == 0;
                    addr[i*8 +: 8] = 8'($urandom);
                    wdata[i*DW +: DW] = DW'($urandom);
                    we[i] = 1'($urandom);
                end
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
